// File: rtl/omp_pkg.sv
// omp_pkg: shared constants and types for the projection datapath.
//   DATA_W / FRAC_W : signed Q10.13 sample format
//   LANES / VEC_W   : lanes per beat and packed beat width
//   ACC_W           : dot-product accumulator width
//   PROD_W          : full-precision lane product width (Q20.26)
//   state_e         : dot-product FSM states
package omp_pkg;

  localparam int DATA_W = 24;
  localparam int FRAC_W = 13;
  localparam int LANES  = 4;
  localparam int VEC_W  = 96;
  localparam int ACC_W  = 56;
  localparam int PROD_W = 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/proj_dot_unit_if.sv
// proj_dot_unit_if: beat/result bundle for proj_dot_unit.
//   master : drives start, len_beats, in_valid, vec_a, vec_b
//   slave  : drives in_ready, dot_out, dot_valid, busy
interface proj_dot_unit_if;
  import omp_pkg::*;

  logic              start;
  logic [7:0]        len_beats;
  logic              in_valid;
  logic              in_ready;
  logic [VEC_W-1:0]  vec_a;
  logic [VEC_W-1:0]  vec_b;
  logic [DATA_W-1:0] dot_out;
  logic              dot_valid;
  logic              busy;

  modport master (
    output start, len_beats, in_valid, vec_a, vec_b,
    input  in_ready, dot_out, dot_valid, busy
  );

  modport slave (
    input  start, len_beats, in_valid, vec_a, vec_b,
    output in_ready, dot_out, dot_valid, busy
  );

endinterface

// File: rtl/proj_dot_unit_dot4_mult.sv
// dot4_mult: first pipeline stage of the dot product. Multiplies the four
// signed Q10.13 lanes of vec_a and vec_b and registers the four Q20.26
// products together with a valid bit.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid      : a beat is being accepted this cycle
//   vec_a, vec_b  : packed lanes, lane k at [24k+23:24k]
//   prod          : packed registered products, lane k at [48k+47:48k]
//   prod_valid    : prod holds a beat accepted on the previous edge
module dot4_mult
  import omp_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [VEC_W-1:0]          vec_a,
  input  logic [VEC_W-1:0]          vec_b,
  output logic [LANES*PROD_W-1:0]   prod,
  output logic                      prod_valid
);

  logic prod_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [DATA_W-1:0] a_lane;
      logic signed [DATA_W-1:0] b_lane;
      logic signed [PROD_W-1:0] prod_next;
      logic signed [PROD_W-1:0] prod_reg;

      assign a_lane = vec_a[gi*DATA_W +: DATA_W];
      assign b_lane = vec_b[gi*DATA_W +: DATA_W];
      // Widen both operands first so the product keeps all 48 bits.
      assign prod_next = PROD_W'(a_lane) * PROD_W'(b_lane);

      always_ff @(posedge clk) begin
        if (rst) begin
          prod_reg <= '0;
        end else if (in_valid) begin
          prod_reg <= prod_next;
        end
      end

      assign prod[gi*PROD_W +: PROD_W] = prod_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_valid_reg <= 1'b0;
    end else begin
      prod_valid_reg <= in_valid;
    end
  end

  assign prod_valid = prod_valid_reg;

endmodule

// File: rtl/proj_dot_unit.sv
// proj_dot_unit: accumulates the dot product of len_beats 4-lane Q10.13
// beats and returns the Q10.13 projection scalar.
//   clk, rst : clock, synchronous active-high reset
//   bus      : proj_dot_unit_if.slave (start/len_beats request, in_valid/
//              in_ready beat handshake with vec_a/vec_b, dot_out/dot_valid
//              result, busy status)
// Build option: define DOT_SAT_EN to saturate the result to the 24-bit range;
// otherwise the result wraps (acc bits [36:13]).
// Pipeline: beat accepted in T -> products registered (T+1) -> accumulator
// updated on the edge ending T+1 -> DONE and dot_valid in T+3.
module proj_dot_unit
  import omp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  proj_dot_unit_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ACC   = ST_ACC;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]              state_reg, state_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic signed [ACC_W-1:0] acc_reg;
  logic [DATA_W-1:0]       dot_out_reg;
  logic                    beat_fire;
  logic                    start_fire;
  logic [LANES*PROD_W-1:0] prod;
  logic                    prod_valid;
  logic signed [ACC_W-1:0] prod_ext [LANES];
  logic signed [ACC_W-1:0] beat_sum;

  // Shift right by FRAC_W (floor) and reduce to DATA_W bits.
  function automatic logic [DATA_W-1:0] reduce_acc(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] sh;
`ifdef DOT_SAT_EN
    logic signed [ACC_W-1:0] sat_max;
    logic signed [ACC_W-1:0] sat_min;
    sat_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    sat_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    sh = a >>> FRAC_W;
    if (sh > sat_max) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end else if (sh < sat_min) begin
      return {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      return sh[DATA_W-1:0];
    end
`else
    sh = a >>> FRAC_W;
    return sh[DATA_W-1:0];
`endif
  endfunction

  // A beat offered while rst is high is never accepted.
  assign bus.in_ready  = (state_reg == S_ACC) && (cnt_reg != 8'd0) && !rst;
  assign beat_fire     = bus.in_valid && bus.in_ready;
  assign start_fire    = (state_reg == S_IDLE) && bus.start;
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.dot_valid = (state_reg == S_DONE);
  assign bus.dot_out   = dot_out_reg;

  dot4_mult u_mult (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (beat_fire),
    .vec_a      (bus.vec_a),
    .vec_b      (bus.vec_b),
    .prod       (prod),
    .prod_valid (prod_valid)
  );

  // Stage 2: sign-extend each product to the accumulator width.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_ext
      assign prod_ext[gi] = ACC_W'($signed(prod[gi*PROD_W +: PROD_W]));
    end
  endgenerate

  assign beat_sum = prod_ext[0] + prod_ext[1] + prod_ext[2] + prod_ext[3];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          cnt_next   = bus.len_beats;
          state_next = (bus.len_beats == 8'd0) ? S_DONE : S_ACC;
        end
      end
      S_ACC: begin
        if (beat_fire) begin
          cnt_next = cnt_reg - 8'd1;
          if (cnt_reg == 8'd1) begin
            state_next = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The accumulator absorbs stage 1 on the same edge that clears
        // prod_valid, so acc_reg is final once nothing is in flight.
        if (!prod_valid && !beat_fire) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= 8'd0;
      acc_reg     <= '0;
      dot_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;

      if (start_fire) begin
        acc_reg <= '0;
      end else if (prod_valid) begin
        acc_reg <= acc_reg + beat_sum;
      end

      if (start_fire && (bus.len_beats == 8'd0)) begin
        dot_out_reg <= '0;
      end else if ((state_reg == S_DRAIN) && (state_next == S_DONE)) begin
        dot_out_reg <= reduce_acc(acc_reg);
      end
    end
  end

endmodule

// File: tb/tb_proj_dot_unit.sv
// tb_proj_dot_unit: directed self-checking bench for proj_dot_unit.
// Inputs change 1 ns after the rising edge; a monitor on the falling edge
// counts accepted beats, dot_valid pulses and in_ready cycles.
module tb_proj_dot_unit;
  import omp_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  proj_dot_unit_if bus ();

  proj_dot_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  int cyc          = 0;
  int acc_cnt      = 0;
  int dv_cnt       = 0;
  int rdy_cnt      = 0;
  int last_acc_cyc = -1;
  int dv_cyc       = -1;
  int start_cyc    = -1;

  always @(negedge clk) begin
    if (bus.in_valid && bus.in_ready && !rst) begin
      acc_cnt      <= acc_cnt + 1;
      last_acc_cyc <= cyc;
    end
    if (bus.dot_valid) begin
      dv_cnt <= dv_cnt + 1;
      dv_cyc <= cyc;
    end
    if (bus.in_ready) rdy_cnt <= rdy_cnt + 1;
    if (bus.start) start_cyc <= cyc;
    cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VEC_W-1:0] splat(input logic [DATA_W-1:0] v);
    return {4{v}};
  endfunction

  task automatic do_start(input logic [7:0] len);
    bus.start     = 1'b1;
    bus.len_beats = len;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic send_beat(input string tag, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    bit done = 1'b0;
    bus.vec_a    = splat(a);
    bus.vec_b    = splat(b);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.in_ready) done = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) chk({tag, "_beat_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_dv(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bus.dot_valid) seen = 1'b1;
      else tick();
    end
    if (!seen) chk({tag, "_dv_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int a0;
    int d0;
    int r0;
    logic [31:0] exp_big;

    bus.start     = 1'b0;
    bus.len_beats = 8'd0;
    bus.in_valid  = 1'b0;
    bus.vec_a     = '0;
    bus.vec_b     = '0;
    rst           = 1'b1;
    repeat (3) tick();

    // Reset values
    chk("rst_dot_out", 32'(bus.dot_out), 32'h0);
    chk("rst_dot_valid", 32'(bus.dot_valid), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    rst = 1'b0;
    tick();
    $display("txn reset: done");

    // len=1, 1.0 * 0.5 on four lanes -> 2.0
    d0 = dv_cnt;
    do_start(8'd1);
    chk("t1_busy", 32'(bus.busy), 32'h1);
    send_beat("t1", 24'h002000, 24'h001000);
    wait_dv("t1");
    chk("t1_dot_out", 32'(bus.dot_out), 32'h004000);
    tick();
    chk("t1_latency", 32'(dv_cyc - last_acc_cyc), 32'd3);
    chk("t1_pulses", 32'(dv_cnt - d0), 32'd1);
    chk("t1_busy_after", 32'(bus.busy), 32'h0);
    chk("t1_dv_after", 32'(bus.dot_valid), 32'h0);
    chk("t1_hold", 32'(bus.dot_out), 32'h004000);
    $display("txn len=1: dot_out=0x%06h", bus.dot_out);

    // len=3, -1.0 * 1.0 with 2-cycle gaps -> -12.0 in Q10.13
    d0 = dv_cnt;
    a0 = acc_cnt;
    do_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      send_beat("t2", 24'hFFE000, 24'h002000);
      if (i < 2) begin
        tick();
        tick();
      end
    end
    wait_dv("t2");
    chk("t2_dot_out", 32'(bus.dot_out), 32'h00FE8000);
    tick();
    chk("t2_beats", 32'(acc_cnt - a0), 32'd3);
    chk("t2_pulses", 32'(dv_cnt - d0), 32'd1);
    $display("txn len=3 stalled: dot_out=0x%06h", bus.dot_out);

    // len=0 -> immediate zero result
    r0 = rdy_cnt;
    do_start(8'd0);
    chk("t3_dot_valid", 32'(bus.dot_valid), 32'h1);
    chk("t3_dot_out", 32'(bus.dot_out), 32'h0);
    tick();
    chk("t3_latency", 32'(dv_cyc - start_cyc), 32'd1);
    chk("t3_no_ready", 32'(rdy_cnt - r0), 32'd0);
    chk("t3_busy_after", 32'(bus.busy), 32'h0);
    $display("txn len=0: dot_out=0x%06h", bus.dot_out);

    // len=4, 32.0 * 32.0 on every lane -> 2^27 after shift
`ifdef DOT_SAT_EN
    exp_big = 32'h007FFFFF;
`else
    exp_big = 32'h00000000;
`endif
    do_start(8'd4);
    for (int i = 0; i < 4; i++) send_beat("t4", 24'h040000, 24'h040000);
    wait_dv("t4");
    chk("t4_dot_out", 32'(bus.dot_out), exp_big);
    tick();
    $display("txn len=4 overflow: dot_out=0x%06h", bus.dot_out);

    // Reset after 2 of 5 beats, with a beat offered during reset
    d0 = dv_cnt;
    do_start(8'd5);
    send_beat("t5", 24'h002000, 24'h002000);
    send_beat("t5", 24'h002000, 24'h002000);
    bus.vec_a    = splat(24'h002000);
    bus.vec_b    = splat(24'h002000);
    bus.in_valid = 1'b1;
    rst          = 1'b1;
    #1;
    chk("t5_ready_in_rst", 32'(bus.in_ready), 32'h0);
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("t5_busy", 32'(bus.busy), 32'h0);
    chk("t5_in_ready", 32'(bus.in_ready), 32'h0);
    chk("t5_dot_out_rst", 32'(bus.dot_out), 32'h0);
    repeat (6) tick();
    chk("t5_no_dv", 32'(dv_cnt - d0), 32'd0);
    do_start(8'd1);
    send_beat("t5b", 24'h002000, 24'h001000);
    wait_dv("t5b");
    chk("t5_restart_dot_out", 32'(bus.dot_out), 32'h004000);
    tick();
    $display("txn reset mid-run then len=1: dot_out=0x%06h", bus.dot_out);

    // start pulsed in DRAIN and DONE is ignored
    d0 = dv_cnt;
    do_start(8'd1);
    send_beat("t6", 24'h002000, 24'h001000);
    chk("t6_busy_drain", 32'(bus.busy), 32'h1);
    bus.start     = 1'b1;
    bus.len_beats = 8'd2;
    tick();
    bus.start     = 1'b0;
    chk("t6_no_early_dv", 32'(bus.dot_valid), 32'h0);
    tick();
    chk("t6_dot_valid", 32'(bus.dot_valid), 32'h1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("t6_idle_after_done", 32'(bus.busy), 32'h0);
    chk("t6_in_ready", 32'(bus.in_ready), 32'h0);
    repeat (5) tick();
    chk("t6_pulses", 32'(dv_cnt - d0), 32'd1);
    chk("t6_busy_end", 32'(bus.busy), 32'h0);
    chk("t6_dot_out", 32'(bus.dot_out), 32'h004000);
    chk("t6_latency", 32'(dv_cyc - last_acc_cyc), 32'd3);
    $display("txn start in drain/done: dot_out=0x%06h", bus.dot_out);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
